// File: rtl/surfboard_pkg.sv
// Shared constants and types for the surfboard 3x3 matrix-multiply datapath.
package surfboard_pkg;

  localparam int ELEMS     = 9;
  localparam int FRAME_LEN = 18;

  typedef logic [4:0] idx_t;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    HOLD = 1'b1
  } loader_state_e;

endpackage

// File: rtl/surfboard_loader.sv
// Serial-to-parallel loader: collects 9 A and 9 B elements per frame and holds
// them for the combinational multiplier until the consumer handshakes.
module surfboard_loader
  import surfboard_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  output logic [W-1:0]     a_out [0:ELEMS-1],
  output logic [W-1:0]     b_out [0:ELEMS-1],
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam idx_t LAST_IDX = idx_t'(FRAME_LEN - 1);

  loader_state_e state_r;
  idx_t          idx_r;
  logic          accept_s;

  // Input handshake is a pure function of the FSM state.
  always_comb begin
    in_ready = (state_r == LOAD);
    accept_s = in_valid && in_ready;
  end

  // Frame assembly FSM, index counter, output registers and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= LOAD;
      idx_r     <= idx_t'(0);
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= {CNT_W{1'b0}};
      for (int i = 0; i < ELEMS; i++) begin
        a_out[i] <= {W{1'b0}};
        b_out[i] <= {W{1'b0}};
      end
    end else begin
      frame_err <= 1'b0;
      case (state_r)
        LOAD: begin
          if (accept_s) begin
            if (idx_r == LAST_IDX) begin
              idx_r <= idx_t'(0);
              if (in_last) begin
                b_out[ELEMS-1] <= in_data;
                state_r        <= HOLD;
                out_valid      <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else if (in_last) begin
              // Early last: the element is dropped and the frame restarts.
              frame_err <= 1'b1;
              idx_r     <= idx_t'(0);
            end else begin
              for (int i = 0; i < ELEMS; i++) begin
                if (idx_r == idx_t'(i)) begin
                  a_out[i] <= in_data;
                end
                if (idx_r == idx_t'(i + ELEMS)) begin
                  b_out[i] <= in_data;
                end
              end
              idx_r <= idx_r + idx_t'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
            state_r   <= LOAD;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= LOAD;
          idx_r     <= idx_t'(0);
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
